rot_key_pulser: RTL and testbench
=================================

Name: rot_key_pulser

Overview:
- Producer side of the rotate-request interface. Turns a raw, bouncy, asynchronous rotate key level into clean single-cycle `rot` pulses for the rotation state machine.
- Synchronises the key, debounces press and release, and emits one pulse per debounced press.
- Optionally auto-repeats while the key is held.
- Sits between the keyboard/button input and the rotation FSM. One `rot` pulse advances the rotation by exactly one step.

Parameters:
- DEBOUNCE_CYCLES, 1000000: cycles the synchronised key must stay stable to accept a press or release (10 ms at 100 MHz); must be >= 1.
- REPEAT_EN, 1: 1 enables auto-repeat while held; 0 gives one pulse per press.
- REPEAT_DELAY, 30000000: cycles from the first pulse to the first repeat pulse; must be >= 1.
- REPEAT_PERIOD, 15000000: cycles between later repeat pulses; must be >= 1.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- key_raw  in  1  raw rotate key level, asynchronous to clock, 1 = pressed
- rot_en  in  1  1 = pulses allowed; 0 = pulses masked (e.g. piece locking or game over)
- rot  out  1  registered single-cycle rotate request to the rotation FSM
- pressed  out  1  registered debounced key level

Behaviour:
- Reset (asynchronous, active-high): synchroniser flops, counter, state = IDLE, rot = 0, pressed = 0. All take effect immediately, without a clock edge.
- Synchroniser: two flops, key_raw -> s1 -> key_s. Only key_s is used downstream.
- One shared counter `cnt`, width $clog2 of the largest parameter plus 1. It is cleared on every state change and otherwise increments by 1 each cycle.
- IDLE: if key_s = 1, go to PRESS_DB.
- PRESS_DB:
  - key_s = 0: return to IDLE (bounce), no pulse.
  - cnt = DEBOUNCE_CYCLES-1: go to HELD and issue a pulse.
- HELD (pressed = 1):
  - key_s = 0: go to REL_DB.
  - Otherwise, if REPEAT_EN and cnt = REPEAT_DELAY-1: go to REPEAT and issue a pulse.
- REPEAT (pressed = 1):
  - key_s = 0: go to REL_DB.
  - cnt = REPEAT_PERIOD-1: issue a pulse, clear cnt, stay in REPEAT.
- REL_DB (pressed stays 1):
  - key_s = 1: return to HELD with cnt cleared and no pulse. The repeat delay restarts.
  - cnt = DEBOUNCE_CYCLES-1: go to IDLE and set pressed = 0.
- Pulse issue: rot is registered. It is high for exactly the one cycle after the state transition that issued it, and never for two consecutive cycles.
- Latency: with key_raw stable high from the first sampling edge E1, rot is high in the cycle after edge E1+DEBOUNCE_CYCLES+2.
- Release timing: pressed falls DEBOUNCE_CYCLES+3 edges after key_raw is first sampled stably low.
- rot_en:
  - It gates only the registered rot output. The FSM and counter advance regardless.
  - A pulse due while rot_en = 0 is dropped, not queued.
  - Raising rot_en while the key is held yields no pulse until the next repeat point.
- Simultaneous events: a key_s change takes priority over a terminal count in the same cycle, in every state.
- Reset mid-operation: everything clears. A key still held after reset is released is treated as a new press: full debounce, then one pulse.
- No combinational path from any input to any output.

Decomposition:
- Shared package rot_key_pkg:
  - state typedef/localparams: IDLE = 3'd0, PRESS_DB = 3'd1, HELD = 3'd2, REPEAT = 3'd3, REL_DB = 3'd4; other encodings recover to IDLE.
  - default timing constants for a 100 MHz clock.
- Natural sub-module: key_sync, the 2-flop synchroniser with asynchronous reset, reusable for the move/drop keys.

Test Plan (bench uses DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8):
- Clean press: key_raw 0->1 sampled at E1 and held 12 cycles with REPEAT_EN=0 -> rot high only in the cycle after E7, pressed rises together with that pulse, no further pulses.
- Bounce: key_raw toggles 1,0,1,0 on consecutive edges, then stays 0 -> rot never asserts, pressed stays 0, state ends in IDLE.
- Auto-repeat: key held 60 cycles with REPEAT_EN=1 and first pulse at cycle T -> pulses at T, T+20, T+28, T+36, T+44, T+52, each exactly 1 cycle wide.
- Release glitch: while HELD, key_raw drops for 2 cycles then returns -> no pulse, pressed stays 1, first repeat comes 20 cycles after re-entering HELD.
- Masking: rot_en = 0 during the first pulse and 1 from T+5 -> no pulse at T, next pulse at T+20.
- Async reset mid-REPEAT: reset asserted between edges -> rot and pressed go 0 immediately. Key still held after reset is released -> one pulse after 4+3 edges.

Source files
------------

// File: rtl/rot_key_pkg.sv
// Shared types and default timing for the key pulser family.
// Default constants assume a 100 MHz core clock.
package rot_key_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      PRESS_DB = 3'd1,
      HELD     = 3'd2,
      REPEAT   = 3'd3,
      REL_DB   = 3'd4
   } state_t;

   localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;   // 10 ms
   localparam int unsigned DEF_REPEAT_DELAY    = 30_000_000;  // 300 ms
   localparam int unsigned DEF_REPEAT_PERIOD   = 15_000_000;  // 150 ms

   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchroniser for an asynchronous key level.
// Latency 2 cycles, no backpressure.
module key_sync (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_async,
   output logic o_sync
);

   logic r_s1;
   logic r_s2;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= i_async;
         r_s2 <= r_s1;
      end
   end

   assign o_sync = r_s2;

endmodule

// File: rtl/rot_key_pulser.sv
// Debounced rotate key to single-cycle rot pulses, with optional auto-repeat.
// First pulse is issued at edge E1+DEBOUNCE_CYCLES+2; rot_en masks (drops) pulses.
module rot_key_pulser
   import rot_key_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter bit          REPEAT_EN       = 1'b1,
   parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic clock,
   input  logic reset,
   input  logic key_raw,
   input  logic rot_en,
   output logic rot,
   output logic pressed
);

   localparam int unsigned MAXP = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
   localparam int unsigned CW   = $clog2(MAXP) + 1;

   localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);

   logic          w_key;
   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_rot;
   logic          r_pressed;

   key_sync u_sync (
      .i_clk   (clock),
      .i_rst   (reset),
      .i_async (key_raw),
      .o_sync  (w_key)
   );

   // Key changes are tested before terminal counts so a change always wins.
   // Pulses are suppressed right after a pulse so rot is never two cycles wide.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_rot     <= 1'b0;
         r_pressed <= 1'b0;
      end else begin
         r_rot <= 1'b0;
         r_cnt <= r_cnt + CW'(1);
         case (r_state)
            IDLE: begin
               if (w_key) begin
                  r_state <= PRESS_DB;
                  r_cnt   <= '0;
               end
            end
            PRESS_DB: begin
               if (!w_key) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end else if (r_cnt == DB_LAST) begin
                  r_state   <= HELD;
                  r_cnt     <= '0;
                  r_pressed <= 1'b1;
                  r_rot     <= rot_en & ~r_rot;
               end
            end
            HELD: begin
               if (!w_key) begin
                  r_state <= REL_DB;
                  r_cnt   <= '0;
               end else if (REPEAT_EN && (r_cnt == RD_LAST)) begin
                  r_state <= REPEAT;
                  r_cnt   <= '0;
                  r_rot   <= rot_en & ~r_rot;
               end
            end
            REPEAT: begin
               if (!w_key) begin
                  r_state <= REL_DB;
                  r_cnt   <= '0;
               end else if (r_cnt == RP_LAST) begin
                  r_cnt <= '0;
                  r_rot <= rot_en & ~r_rot;
               end
            end
            REL_DB: begin
               if (w_key) begin
                  r_state <= HELD;
                  r_cnt   <= '0;
               end else if (r_cnt == DB_LAST) begin
                  r_state   <= IDLE;
                  r_cnt     <= '0;
                  r_pressed <= 1'b0;
               end
            end
            default: begin
               r_state   <= IDLE;
               r_cnt     <= '0;
               r_pressed <= 1'b0;
            end
         endcase
      end
   end

   assign rot     = r_rot;
   assign pressed = r_pressed;

endmodule

// File: tb/tb_rot_key_pulser.sv
// Directed bench for rot_key_pulser with DEBOUNCE=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
// dut0 has auto-repeat disabled, dut1 enabled; both share the same key stimulus.
module tb_rot_key_pulser;

   logic clock = 1'b0;
   logic reset;
   logic key_raw;
   logic rot_en;
   logic rot0, pressed0;
   logic rot1, pressed1;

   int n_vec  = 0;
   int n_err  = 0;
   int edge_n = 0;
   int wide_viol = 0;
   logic prev_rot1 = 1'b0;
   int pulses[$];
   int exp_p[$];

   typedef struct {
      logic key;
      logic en;
      logic exp_rot;
      logic exp_prs;
   } vec_t;

   vec_t vecs[32];

   rot_key_pulser #(
      .DEBOUNCE_CYCLES (4),
      .REPEAT_EN       (1'b0),
      .REPEAT_DELAY    (20),
      .REPEAT_PERIOD   (8)
   ) dut0 (
      .clock   (clock),
      .reset   (reset),
      .key_raw (key_raw),
      .rot_en  (rot_en),
      .rot     (rot0),
      .pressed (pressed0)
   );

   rot_key_pulser #(
      .DEBOUNCE_CYCLES (4),
      .REPEAT_EN       (1'b1),
      .REPEAT_DELAY    (20),
      .REPEAT_PERIOD   (8)
   ) dut1 (
      .clock   (clock),
      .reset   (reset),
      .key_raw (key_raw),
      .rot_en  (rot_en),
      .rot     (rot1),
      .pressed (pressed1)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Edge numbering: step() drives inputs, then edge edge_n+1 samples them.
   task automatic step(input logic k, input logic en);
      key_raw = k;
      rot_en  = en;
      @(posedge clock);
      #1;
      edge_n++;
      if (rot1) pulses.push_back(edge_n);
      if (rot1 && prev_rot1) wide_viol++;
      prev_rot1 = rot1;
   endtask

   task automatic check_pulses(input string name);
      check_int({name, "_count"}, pulses.size(), exp_p.size());
      for (int i = 0; i < exp_p.size(); i++)
         check_int($sformatf("%s_pulse%0d", name, i),
                   (i < pulses.size()) ? pulses[i] : -1, exp_p[i]);
   endtask

   task automatic start_seq();
      edge_n = 0;
      pulses.delete();
   endtask

   initial begin
      int drop;
      reset   = 1'b1;
      key_raw = 1'b0;
      rot_en  = 1'b1;
      #1;
      check("reset_rot0", rot0, 1'b0);
      check("reset_rot1", rot1, 1'b0);
      check("reset_pressed0", pressed0, 1'b0);
      check("reset_pressed1", pressed1, 1'b0);
      repeat (2) @(posedge clock);
      #2;
      reset = 1'b0;
      repeat (3) step(1'b0, 1'b1);

      // Clean press held 12 edges, then released; then a 1,0,1,0 bounce.
      for (int k = 0; k < 22; k++) begin
         vecs[k].key     = (k + 1 <= 12);
         vecs[k].en      = 1'b1;
         vecs[k].exp_rot = (k + 1 == 7);
         vecs[k].exp_prs = (k + 1 >= 7) && (k + 1 <= 18);
      end
      for (int k = 22; k < 32; k++) begin
         vecs[k].key     = (k == 22) || (k == 24);
         vecs[k].en      = 1'b1;
         vecs[k].exp_rot = 1'b0;
         vecs[k].exp_prs = 1'b0;
      end
      for (int i = 0; i < 32; i++) begin
         step(vecs[i].key, vecs[i].en);
         check($sformatf("vec%0d_rot0", i), rot0, vecs[i].exp_rot);
         check($sformatf("vec%0d_rot1", i), rot1, vecs[i].exp_rot);
         check($sformatf("vec%0d_pressed0", i), pressed0, vecs[i].exp_prs);
         check($sformatf("vec%0d_pressed1", i), pressed1, vecs[i].exp_prs);
      end

      // Auto-repeat: held 60 edges.
      start_seq();
      repeat (60) step(1'b1, 1'b1);
      repeat (12) step(1'b0, 1'b1);
      exp_p = '{7, 27, 35, 43, 51, 59};
      check_pulses("autorepeat");
      check("autorepeat_released", pressed1, 1'b0);

      // Release glitch: key low on edges 10 and 11 only.
      start_seq();
      drop = 0;
      for (int e = 1; e <= 40; e++) begin
         step(!((e == 10) || (e == 11)), 1'b1);
         if ((e >= 7) && (pressed1 !== 1'b1)) drop++;
      end
      check_int("glitch_pressed_drops", drop, 0);
      exp_p = '{7, 34};
      check_pulses("glitch");
      repeat (12) step(1'b0, 1'b1);
      check("glitch_released", pressed1, 1'b0);

      // Masking: rot_en low through the first pulse, high from T+5.
      start_seq();
      for (int e = 1; e <= 30; e++) step(1'b1, e >= 13);
      exp_p = '{27};
      check_pulses("mask");
      repeat (12) step(1'b0, 1'b1);

      // Asynchronous reset while a REPEAT pulse is on the output.
      start_seq();
      repeat (35) step(1'b1, 1'b1);
      check("prereset_rot1", rot1, 1'b1);
      check("prereset_pressed1", pressed1, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      check("async_reset_rot1", rot1, 1'b0);
      check("async_reset_pressed1", pressed1, 1'b0);
      check("async_reset_pressed0", pressed0, 1'b0);
      @(posedge clock);
      @(posedge clock);
      #2;
      reset = 1'b0;
      prev_rot1 = 1'b0;
      start_seq();
      repeat (12) step(1'b1, 1'b1);
      exp_p = '{7};
      check_pulses("post_reset");
      check("post_reset_pressed1", pressed1, 1'b1);
      repeat (12) step(1'b0, 1'b1);

      check_int("rot_single_cycle", wide_viol, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
